// File: rtl/uart_bus_responder_pkg.sv
// uart_bus_responder_pkg
//   Shared constants and state encodings for the UART bus responder.
//   UartDiv   : default clocks per 1/16 bit period (11.0592 MHz / (16*115200)).
//   MemValue  : width of the shared memory/UART data bus.
//   Oversample: sub-bit ticks per serial bit.
package uart_bus_responder_pkg;

    localparam int unsigned UartDiv    = 6;
    localparam int unsigned MemValue   = 16;
    localparam int unsigned Oversample = 16;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_bus_responder_rx_sampler.sv
// uart_rx_sampler
//   8N1 receiver: two-flop rxd synchronizer, 1/16-bit tick divider and RX FSM.
//   Ports:
//     clk, rst   : clock, asynchronous active-low reset
//     rxd        : asynchronous serial input (idle high)
//     rx_byte    : last correctly framed byte
//     rx_valid   : one-cycle pulse, rx_byte updated
//     frame_err  : one-cycle pulse, stop bit sampled low (byte discarded)
module uart_rx_sampler
    import uart_bus_responder_pkg::*;
#(
    parameter int unsigned DIV = UartDiv
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam logic [7:0] DivLast = 8'(DIV - 1);

    rx_state_t  state, state_nx;
    logic       rxd_meta, rxd_sync, rxd_prev;
    logic [7:0] div_cnt;
    logic [3:0] tick_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shift;
    logic       tick, shift_en, commit, bad_stop;

    assign tick = (div_cnt == DivLast);

    always_comb begin
        state_nx = state;
        shift_en = 1'b0;
        commit   = 1'b0;
        bad_stop = 1'b0;
        case (state)
            RX_IDLE:  if (rxd_prev && !rxd_sync) state_nx = RX_START;
            // Half a bit into the start bit: a high line means a glitch.
            RX_START: if (tick && tick_cnt == 4'd7) state_nx = rxd_sync ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (tick && tick_cnt == 4'd15) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) state_nx = RX_STOP;
                end
            end
            RX_STOP: begin
                if (tick && tick_cnt == 4'd15) begin
                    state_nx = RX_IDLE;
                    commit   = rxd_sync;
                    bad_stop = !rxd_sync;
                end
            end
            default:  state_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RX_IDLE;
            rxd_meta  <= 1'b1;
            rxd_sync  <= 1'b1;
            rxd_prev  <= 1'b1;
            div_cnt   <= '0;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            rxd_meta  <= rxd;
            rxd_sync  <= rxd_meta;
            rxd_prev  <= rxd_sync;
            rx_valid  <= commit;
            frame_err <= bad_stop;
            // Counters are held at zero while idle so a detected start bit
            // always begins counting from a clean phase.
            if (state == RX_IDLE) begin
                div_cnt  <= '0;
                tick_cnt <= '0;
                bit_idx  <= '0;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 8'd1;
                if (tick) begin
                    // Re-align to mid-bit after the half-bit start check;
                    // otherwise wrap naturally every 16 ticks.
                    tick_cnt <= (state == RX_START && tick_cnt == 4'd7) ? '0 : tick_cnt + 4'd1;
                end
            end
            if (shift_en) begin
                shift   <= {rxd_sync, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (commit) rx_byte <= shift;
        end
    end

endmodule

// File: rtl/uart_bus_responder.sv
// uart_bus_responder
//   Device-side UART bridge model answering rdn/wrn strobes on the low byte
//   of the shared data bus; 8N1 transmit on txd, receive on rxd.
//   Ports:
//     clk, rst          : clock, asynchronous active-low reset
//     rdn, wrn          : read / write strobes, active low
//     bus_data_i        : bus as driven by the controller ([7:0] used)
//     bus_data_o        : {8'h00, rbr}; bus_data_oe = ~rdn
//     data_ready        : receive buffer holds an unread byte
//     tbre, tsre        : transmit holding / shift register empty
//     txd, rxd          : serial out / in (idle high)
//     rx_overrun        : sticky, byte received while data_ready=1
//     tx_overrun        : sticky, write while tbre=0
//     frame_err         : one-cycle pulse on a bad stop bit
module uart_bus_responder
    import uart_bus_responder_pkg::*;
#(
    parameter int unsigned DIV = UartDiv
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdn,
    input  logic                wrn,
    input  logic [MemValue-1:0] bus_data_i,
    output logic [MemValue-1:0] bus_data_o,
    output logic                bus_data_oe,
    output logic                data_ready,
    output logic                tbre,
    output logic                tsre,
    output logic                txd,
    input  logic                rxd,
    output logic                rx_overrun,
    output logic                tx_overrun,
    output logic                frame_err
);

    localparam logic [11:0] BitLast = 12'(Oversample * DIV - 1);

    tx_state_t   tx_state, tx_nx;
    logic        rdn_prev, wrn_prev, wr_fall, rd_rise;
    logic [7:0]  thr, tsr, rbr, rx_byte;
    logic [11:0] baud_cnt;
    logic [2:0]  tx_bit;
    logic        bit_end, tx_load, tx_done, rx_valid;
    logic        unused_bus_hi;

    assign unused_bus_hi = ^bus_data_i[MemValue-1:8];
    assign wr_fall       = !wrn && wrn_prev;
    assign rd_rise       = rdn && !rdn_prev;
    assign bus_data_o    = {{(MemValue - 8){1'b0}}, rbr};
    assign bus_data_oe   = !rdn;
    assign bit_end       = (baud_cnt == BitLast);

    uart_rx_sampler #(.DIV(DIV)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    always_comb begin
        tx_nx   = tx_state;
        tx_load = 1'b0;
        tx_done = 1'b0;
        txd     = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (!tbre) begin
                    tx_load = 1'b1;
                    tx_nx   = TX_START;
                end
            end
            TX_START: begin
                txd = 1'b0;
                if (bit_end) tx_nx = TX_DATA;
            end
            TX_DATA: begin
                txd = tsr[tx_bit];
                if (bit_end && tx_bit == 3'd7) tx_nx = TX_STOP;
            end
            TX_STOP: begin
                if (bit_end) begin
                    // A pending byte goes straight into the next start bit.
                    if (!tbre) begin
                        tx_load = 1'b1;
                        tx_nx   = TX_START;
                    end else begin
                        tx_done = 1'b1;
                        tx_nx   = TX_IDLE;
                    end
                end
            end
            default: tx_nx = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            baud_cnt <= '0;
            tx_bit   <= '0;
            tsr      <= '0;
            tsre     <= 1'b1;
        end else begin
            tx_state <= tx_nx;
            baud_cnt <= (tx_state == TX_IDLE || bit_end) ? '0 : baud_cnt + 12'd1;
            if (tx_state == TX_DATA && bit_end) tx_bit <= tx_bit + 3'd1;
            if (tx_load) begin
                tsr  <= thr;
                tsre <= 1'b0;
            end else if (tx_done) begin
                tsre <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdn_prev   <= 1'b1;
            wrn_prev   <= 1'b1;
            thr        <= '0;
            tbre       <= 1'b1;
            tx_overrun <= 1'b0;
            rbr        <= '0;
            data_ready <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rdn_prev <= rdn;
            wrn_prev <= wrn;
            // Write acceptance needs tbre=1 while a TX load needs tbre=0,
            // so the two tbre updates can never collide.
            if (wr_fall) begin
                if (tbre) begin
                    thr  <= bus_data_i[7:0];
                    tbre <= 1'b0;
                end else begin
                    tx_overrun <= 1'b1;
                end
            end
            if (tx_load) tbre <= 1'b1;
            // A freshly committed byte wins over a concurrent read-clear.
            if (rx_valid) begin
                rbr        <= rx_byte;
                data_ready <= 1'b1;
                if (data_ready) rx_overrun <= 1'b1;
            end else if (rd_rise) begin
                data_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_bus_responder.sv
module tb_uart_bus_responder;
    import uart_bus_responder_pkg::*;

    localparam int unsigned DIV = 6;
    localparam int BIT   = 16 * DIV;
    localparam int FRAME = 10 * BIT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdn = 1'b1;
    logic        wrn = 1'b1;
    logic        rxd = 1'b1;
    logic [15:0] bus_data_i = '0;
    logic [15:0] bus_data_o;
    logic        bus_data_oe, data_ready, tbre, tsre, txd;
    logic        rx_overrun, tx_overrun, frame_err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int ferr_cnt = 0;
    int txd_falls = 0;
    logic txd_q = 1'b1;

    logic [7:0] mon_byte[$];
    int         mon_start[$];
    logic       mon_stop[$];
    logic       mon_prev = 1'b1;

    uart_bus_responder #(.DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdn        (rdn),
        .wrn        (wrn),
        .bus_data_i (bus_data_i),
        .bus_data_o (bus_data_o),
        .bus_data_oe(bus_data_oe),
        .data_ready (data_ready),
        .tbre       (tbre),
        .tsre       (tsre),
        .txd        (txd),
        .rxd        (rxd),
        .rx_overrun (rx_overrun),
        .tx_overrun (tx_overrun),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ferr_cnt  <= ferr_cnt + ((frame_err === 1'b1) ? 1 : 0);
        txd_falls <= txd_falls + ((txd_q === 1'b1 && txd === 1'b0) ? 1 : 0);
        txd_q     <= txd;
    end

    // Serial line decoder: mid-bit samples from the first low after idle.
    initial begin : tx_monitor
        logic [7:0] b;
        int st;
        b = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && mon_prev === 1'b1 && txd === 1'b0) begin
                st = cyc;
                repeat (BIT / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    b[i] = txd;
                end
                repeat (BIT) @(negedge clk);
                mon_byte.push_back(b);
                mon_start.push_back(st);
                mon_stop.push_back(txd);
            end
            mon_prev = txd;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; t is the edge index at which the write is taken.
    task automatic do_write(input logic [15:0] d, input int hold, output int t);
        t = cyc + 1;
        wrn = 1'b0;
        bus_data_i = d;
        cycles(hold);
        wrn = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            cycles(BIT);
        end
        rxd = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_dr;
        logic [7:0] exp_rbr;
        int         exp_ferr;
        logic       do_read;
        logic       exp_ov;
    } rx_vec_t;

    rx_vec_t tbl[5];

    initial begin : stimulus
        int t, l, lprev, f0, falls0, hold, gap, rem, n;
        logic [9:0]  fr;
        logic [15:0] d;
        logic [7:0]  exp_b[$];
        int          exp_l[$];
        logic        ov_exp, m_dr, m_ov, stp;
        logic [7:0]  m_rbr, rb;
        int          m_ferr;

        tbl[0] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 0, 1'b1, 1'b0};
        tbl[1] = '{8'h11, 1'b1, 1'b1, 8'h11, 0, 1'b0, 1'b0};
        tbl[2] = '{8'h22, 1'b1, 1'b1, 8'h22, 0, 1'b1, 1'b1};
        tbl[3] = '{8'h5A, 1'b0, 1'b0, 8'h22, 1, 1'b0, 1'b1};
        tbl[4] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0, 1'b1, 1'b1};

        // Reset state
        cycles(3);
        check("rst_txd",  32'(txd), 32'd1);
        check("rst_tbre", 32'(tbre), 32'd1);
        check("rst_tsre", 32'(tsre), 32'd1);
        check("rst_dr",   32'(data_ready), 32'd0);
        check("rst_bus",  32'(bus_data_o), 32'd0);
        check("rst_oe",   32'(bus_data_oe), 32'd0);
        check("rst_rxov", 32'(rx_overrun), 32'd0);
        check("rst_txov", 32'(tx_overrun), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        rst = 1'b1;
        cycles(2);

        // Single write of 0x55, strobe held two cycles
        wrn = 1'b0;
        bus_data_i = 16'hAB55;
        cycles(1);
        check("wr_tbre_low", 32'(tbre), 32'd0);
        check("wr_tsre_idle", 32'(tsre), 32'd1);
        cycles(1);
        check("load_tbre", 32'(tbre), 32'd1);
        check("load_txd_start", 32'(txd), 32'd0);
        check("load_tsre", 32'(tsre), 32'd0);
        wrn = 1'b1;
        fr = {1'b1, 8'h55, 1'b0};
        cycles(BIT / 2);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("tx55_bit%0d", k), 32'(txd), 32'(fr[k]));
            if (k < 9) cycles(BIT);
        end
        cycles(BIT / 2 - 1);
        check("tx55_tsre_before_end", 32'(tsre), 32'd0);
        cycles(1);
        check("tx55_tsre_end", 32'(tsre), 32'd1);
        check("tx55_txd_idle", 32'(txd), 32'd1);
        check("tx55_no_overrun", 32'(tx_overrun), 32'd0);

        // Back-to-back frames, then a write while tbre=0
        cycles(10);
        mon_byte.delete(); mon_start.delete(); mon_stop.delete();
        do_write(16'h003C, 1, t);
        n = 0;
        while (tbre !== 1'b1 && n < 50) begin
            cycles(1);
            n++;
        end
        check("b2b_tbre_back", 32'(tbre), 32'd1);
        do_write(16'h00C5, 1, t);
        cycles(10);
        check("b2b_no_ov_yet", 32'(tx_overrun), 32'd0);
        do_write(16'h00FF, 1, t);
        check("b2b_tx_overrun", 32'(tx_overrun), 32'd1);
        cycles(2 * FRAME + 100);
        check("b2b_frames", 32'(mon_byte.size()), 32'd2);
        if (mon_byte.size() == 2) begin
            check("b2b_byte0", 32'(mon_byte[0]), 32'h3C);
            check("b2b_byte1", 32'(mon_byte[1]), 32'hC5);
            check("b2b_gap", 32'(mon_start[1] - mon_start[0]), 32'(FRAME));
        end
        check("b2b_tsre", 32'(tsre), 32'd1);

        // Async reset in the middle of a frame
        do_write(16'h000F, 1, t);
        cycles(300);
        rst = 1'b0;
        #1;
        check("abort_txd",  32'(txd), 32'd1);
        check("abort_tbre", 32'(tbre), 32'd1);
        check("abort_tsre", 32'(tsre), 32'd1);
        check("abort_dr",   32'(data_ready), 32'd0);
        check("abort_txov", 32'(tx_overrun), 32'd0);
        cycles(2);
        falls0 = txd_falls;
        rst = 1'b1;
        cycles(FRAME + 100);
        check("abort_no_edges", 32'(txd_falls - falls0), 32'd0);

        // Randomized writes against a timing model of the holding register
        mon_byte.delete(); mon_start.delete(); mon_stop.delete();
        lprev = -100000;
        ov_exp = 1'b0;
        for (int k = 0; k < 10; k++) begin
            d    = 16'($urandom);
            hold = int'($urandom_range(1, 3));
            gap  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40))
                                               : int'($urandom_range(200, 1100));
            do_write(d, hold, t);
            if (t > lprev) begin
                l = (t + 1 > lprev + FRAME) ? t + 1 : lprev + FRAME;
                exp_b.push_back(d[7:0]);
                exp_l.push_back(l);
                lprev = l;
            end else begin
                ov_exp = 1'b1;
            end
            cycles(gap);
        end
        rem = lprev + FRAME + 50 - cyc;
        if (rem > 0) cycles(rem);
        check("rnd_tx_overrun", 32'(tx_overrun), 32'(ov_exp));
        check("rnd_tx_frames", 32'(mon_byte.size()), 32'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < mon_byte.size(); i++) begin
            check($sformatf("rnd_tx_byte%0d", i), 32'(mon_byte[i]), 32'(exp_b[i]));
            check($sformatf("rnd_tx_start%0d", i), 32'(mon_start[i]), 32'(exp_l[i]));
            check($sformatf("rnd_tx_stop%0d", i), 32'(mon_stop[i]), 32'd1);
        end

        // Receive vector table
        for (int i = 0; i < 5; i++) begin
            f0 = ferr_cnt;
            send_frame(tbl[i].data, tbl[i].stop);
            cycles(20);
            check($sformatf("rx%0d_dr", i), 32'(data_ready), 32'(tbl[i].exp_dr));
            check($sformatf("rx%0d_bus", i), 32'(bus_data_o), {24'h0, tbl[i].exp_rbr});
            check($sformatf("rx%0d_ferr", i), 32'(ferr_cnt - f0), 32'(tbl[i].exp_ferr));
            check($sformatf("rx%0d_ov", i), 32'(rx_overrun), 32'(tbl[i].exp_ov));
            if (tbl[i].do_read) begin
                rdn = 1'b0;
                cycles(1);
                check($sformatf("rx%0d_oe", i), 32'(bus_data_oe), 32'd1);
                check($sformatf("rx%0d_rd_bus", i), 32'(bus_data_o), {24'h0, tbl[i].exp_rbr});
                cycles(2);
                rdn = 1'b1;
                check($sformatf("rx%0d_dr_held", i), 32'(data_ready), 32'd1);
                cycles(1);
                check($sformatf("rx%0d_dr_clr", i), 32'(data_ready), 32'd0);
                check($sformatf("rx%0d_oe_off", i), 32'(bus_data_oe), 32'd0);
            end
            cycles(10);
        end

        // Short low glitch on rxd: no byte, no framing error
        f0 = ferr_cnt;
        rxd = 1'b0;
        cycles(4 * DIV);
        rxd = 1'b1;
        cycles(FRAME + 50);
        check("glitch_dr", 32'(data_ready), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("glitch_bus", 32'(bus_data_o), 32'h00A5);

        // Randomized receive traffic against a buffer/flag model
        rst = 1'b0;
        cycles(2);
        rst = 1'b1;
        cycles(2);
        m_dr = 1'b0; m_ov = 1'b0; m_rbr = '0; m_ferr = 0;
        f0 = ferr_cnt;
        for (int k = 0; k < 8; k++) begin
            rb  = 8'($urandom);
            stp = ($urandom_range(0, 3) != 0);
            send_frame(rb, stp);
            if (stp) begin
                if (m_dr) m_ov = 1'b1;
                m_dr  = 1'b1;
                m_rbr = rb;
            end else begin
                m_ferr++;
            end
            cycles(20);
            check($sformatf("rnd_rx%0d_dr", k), 32'(data_ready), 32'(m_dr));
            check($sformatf("rnd_rx%0d_bus", k), 32'(bus_data_o), {24'h0, m_rbr});
            check($sformatf("rnd_rx%0d_ov", k), 32'(rx_overrun), 32'(m_ov));
            check($sformatf("rnd_rx%0d_ferr", k), 32'(ferr_cnt - f0), 32'(m_ferr));
            if ($urandom_range(0, 1) == 1) begin
                rdn = 1'b0;
                cycles(int'($urandom_range(1, 4)));
                rdn = 1'b1;
                cycles(1);
                m_dr = 1'b0;
                check($sformatf("rnd_rx%0d_rdclr", k), 32'(data_ready), 32'(m_dr));
            end
            cycles(int'($urandom_range(1, 60)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
